// File: rtl/dkong_dma_pkg.sv
// rtl/dkong_dma_pkg.sv - shared types and constants for the sprite DMA engine
// Contents: FSM state enum, register window offsets, count width, and the
// Z80 master/slave bus structs used on the system bus and into the sysmux.
package dkong_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WR,
        DONE
    } dma_state_t;

    localparam logic [3:0] DMA_SRC  = 4'h0;
    localparam logic [3:0] DMA_CNT  = 4'h1;
    localparam logic [3:0] DMA_DST  = 4'h2;
    localparam logic [3:0] DMA_DCNT = 4'h3;
    localparam logic [3:0] DMA_MODE = 4'h8;

    localparam int DMA_CNT_W = 14;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dmaster;
        logic        rdn;
        logic        wrn;
        logic        inta;
    } z80_master_bus_t;

    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } z80_slave_bus_t;

    localparam z80_master_bus_t MBUS_IDLE = '{
        addr:    16'h0000,
        dmaster: 8'h00,
        rdn:     1'b1,
        wrn:     1'b1,
        inta:    1'b0
    };

endpackage

// File: rtl/dkong_dma_if.sv
// rtl/dkong_dma_if.sv - bus bundle between the DMA engine and the system
// Signals: ena/ibus/obus (register window), drq (dma_rdy), busrq_n/busak_n
// (CPU bus handover), mbus/mresp (DMA master side), busy/tc (status).
// Modport slave is the DMA engine; modport master is the system around it.
interface dkong_dma_if;
    import dkong_dma_pkg::*;

    logic            ena;
    z80_master_bus_t ibus;
    z80_slave_bus_t  obus;
    logic            drq;
    logic            busrq_n;
    logic            busak_n;
    z80_master_bus_t mbus;
    z80_slave_bus_t  mresp;
    logic            busy;
    logic            tc;

    modport slave (
        input  ena, ibus, drq, busak_n, mresp,
        output obus, busrq_n, mbus, busy, tc
    );

    modport master (
        output ena, ibus, drq, busak_n, mresp,
        input  obus, busrq_n, mbus, busy, tc
    );

endinterface

// File: rtl/dkong_dma_regs.sv
// rtl/dkong_dma_regs.sv - programming registers, byte pointer and status read
// Ports: clk, rst, ena/ibus (register window), busy/tc (status in),
// step (advance src/dst, decrement cnt), src/dst/cnt/mode (to FSM),
// mode_wr (mode written this cycle), rdata (latched read data).
module dkong_dma_regs
    import dkong_dma_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  z80_master_bus_t      ibus,
    input  logic                 busy,
    input  logic                 tc,
    input  logic                 step,
    output logic [15:0]          src,
    output logic [15:0]          dst,
    output logic [DMA_CNT_W-1:0] cnt,
    output logic [1:0]           mode,
    output logic                 mode_wr,
    output logic [7:0]           rdata
);

    logic wrn_d;
    logic ptr;
    logic we;
    logic unused_bits;

    // Only the first cycle of a CPU write strobe is taken, so a long wrn
    // low period still produces exactly one register write.
    assign we      = ena & ~ibus.wrn & wrn_d & ~busy;
    assign mode_wr = we & (ibus.addr[3:0] == DMA_MODE);

    // The window is selected by ena; upper address bits and inta carry no meaning here.
    assign unused_bits = ^{ibus.addr[15:4], ibus.inta};

    always_ff @(posedge clk) begin
        if (rst) begin
            wrn_d <= 1'b1;
            ptr   <= 1'b0;
            src   <= '0;
            dst   <= '0;
            cnt   <= '0;
            mode  <= '0;
            rdata <= '0;
        end else begin
            wrn_d <= ibus.wrn;
            if (we) begin
                case (ibus.addr[3:0])
                    DMA_SRC: begin
                        if (ptr) src[15:8] <= ibus.dmaster;
                        else     src[7:0]  <= ibus.dmaster;
                        ptr <= ~ptr;
                    end
                    DMA_CNT: begin
                        if (ptr) cnt[DMA_CNT_W-1:8] <= ibus.dmaster[DMA_CNT_W-9:0];
                        else     cnt[7:0]           <= ibus.dmaster;
                        ptr <= ~ptr;
                    end
                    DMA_DST: begin
                        if (ptr) dst[15:8] <= ibus.dmaster;
                        else     dst[7:0]  <= ibus.dmaster;
                        ptr <= ~ptr;
                    end
                    DMA_DCNT: ptr <= ~ptr;
                    DMA_MODE: begin
                        mode <= ibus.dmaster[1:0];
                        ptr  <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (step) begin
                src <= src + 16'd1;
                dst <= dst + 16'd1;
                cnt <= cnt - DMA_CNT_W'(1);
            end
            if (ena & ~ibus.rdn) begin
                rdata <= (ibus.addr[3:0] == DMA_MODE) ? {6'b0, tc, busy} : 8'h00;
            end
        end
    end

endmodule

// File: rtl/dkong_dma.sv
// rtl/dkong_dma.sv - single-shot sprite RAM to object RAM DMA engine
// Ports: clk, rst (sync, active high), bus (dkong_dma_if.slave): register
// window ena/ibus/obus, drq trigger, busrq_n/busak_n CPU handover,
// mbus/mresp DMA master side, busy and sticky tc.
// Each byte is an address-setup cycle plus RD_CYCLES of rdn, then an
// address-setup cycle plus WR_CYCLES of wrn; mwait low freezes the strobe.
module dkong_dma
    import dkong_dma_pkg::*;
#(
    parameter int RD_CYCLES = 4,
    parameter int WR_CYCLES = 4
) (
    input logic       clk,
    input logic       rst,
    dkong_dma_if.slave bus
);

    dma_state_t           state;
    logic                 setup;
    logic [7:0]           stb_cnt;
    z80_master_bus_t      mbus_q;
    logic                 busrq_q;
    logic                 busy_q;
    logic                 tc_q;
    logic                 drq_d;

    logic [15:0]          src;
    logic [15:0]          dst;
    logic [DMA_CNT_W-1:0] cnt;
    logic [1:0]           mode;
    logic                 mode_wr;
    logic [7:0]           rdata;

    logic                 trig;
    logic                 rd_end;
    logic                 wr_end;
    logic                 step;

    assign trig   = bus.drq & ~drq_d & (mode == 2'b11);
    assign rd_end = ~setup & bus.mresp.mwait & (stb_cnt == 8'(RD_CYCLES - 1));
    assign wr_end = ~setup & bus.mresp.mwait & (stb_cnt == 8'(WR_CYCLES - 1));
    assign step   = (state == WR) & wr_end & (cnt != '0);

    dkong_dma_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .ena     (bus.ena),
        .ibus    (bus.ibus),
        .busy    (busy_q),
        .tc      (tc_q),
        .step    (step),
        .src     (src),
        .dst     (dst),
        .cnt     (cnt),
        .mode    (mode),
        .mode_wr (mode_wr),
        .rdata   (rdata)
    );

    assign bus.mbus    = mbus_q;
    assign bus.busrq_n = busrq_q;
    assign bus.busy    = busy_q;
    assign bus.tc      = tc_q;
    assign bus.obus    = '{dslave: rdata, mwait: 1'b1};

    // mbus_q.dmaster doubles as the data register: it holds the byte read in
    // RD and is what WR drives onto the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            setup   <= 1'b0;
            stb_cnt <= '0;
            mbus_q  <= MBUS_IDLE;
            busrq_q <= 1'b1;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            drq_d   <= 1'b0;
        end else begin
            drq_d <= bus.drq;
            if (mode_wr) tc_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (trig) begin
                        state   <= REQ;
                        busrq_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!bus.busak_n) begin
                        state       <= RD;
                        setup       <= 1'b1;
                        stb_cnt     <= '0;
                        mbus_q.addr <= src;
                    end
                end
                RD: begin
                    if (setup) begin
                        setup      <= 1'b0;
                        mbus_q.rdn <= 1'b0;
                    end else if (bus.mresp.mwait) begin
                        if (rd_end) begin
                            state          <= WR;
                            setup          <= 1'b1;
                            stb_cnt        <= '0;
                            mbus_q.rdn     <= 1'b1;
                            mbus_q.addr    <= dst;
                            mbus_q.dmaster <= bus.mresp.dslave;
                        end else begin
                            stb_cnt <= stb_cnt + 8'd1;
                        end
                    end
                end
                WR: begin
                    if (setup) begin
                        setup      <= 1'b0;
                        mbus_q.wrn <= 1'b0;
                    end else if (bus.mresp.mwait) begin
                        if (wr_end) begin
                            stb_cnt <= '0;
                            if (cnt == '0) begin
                                state   <= DONE;
                                mbus_q  <= MBUS_IDLE;
                                busrq_q <= 1'b1;
                                tc_q    <= 1'b1;
                            end else if (!bus.busak_n) begin
                                // src is stepped on this same edge, so address the next byte directly.
                                state          <= RD;
                                setup          <= 1'b1;
                                mbus_q.wrn     <= 1'b1;
                                mbus_q.dmaster <= 8'h00;
                                mbus_q.addr    <= src + 16'd1;
                            end else begin
                                state  <= REQ;
                                mbus_q <= MBUS_IDLE;
                            end
                        end else begin
                            stb_cnt <= stb_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.busak_n) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dkong_dma.sv
// tb/tb_dkong_dma.sv - directed self-checking bench for dkong_dma
// Memory, CPU bus-acknowledge and mwait models run on the falling edge;
// the stimulus process acts 1 ns after each falling edge.
module tb_dkong_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dkong_dma_if bus ();

    dkong_dma #(.RD_CYCLES(4), .WR_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q [$];
    logic [15:0] wr_q [$];
    logic [7:0]  wd_q [$];
    int          rd_t [$];
    int          rl_q [$];
    int  cyc = 0, gap_err = 0, nreq = 0, rd_len = 0, ack_cnt = 0;
    int  stall_gen = 0, stall_seen = 0, stall_left = 0;
    bit  prev_rdn = 1'b1, prev_wrn = 1'b1, prev_busrq = 1'b1, mem_init = 1'b0;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory, CPU and bus monitor.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
            mem_init = 1'b1;
        end
        cyc++;
        if (bus.mbus.rdn === 1'b0 && prev_rdn) begin
            rd_q.push_back(bus.mbus.addr);
            rd_t.push_back(cyc);
            if (!prev_wrn) gap_err++;
        end
        if (bus.mbus.wrn === 1'b0 && prev_wrn) begin
            wr_q.push_back(bus.mbus.addr);
            wd_q.push_back(bus.mbus.dmaster);
            mem[bus.mbus.addr] = bus.mbus.dmaster;
            if (!prev_rdn) gap_err++;
        end
        if (bus.mbus.rdn === 1'b0 && bus.mbus.wrn === 1'b0) gap_err++;
        if (bus.mbus.rdn === 1'b0) rd_len++;
        else if (rd_len > 0) begin
            rl_q.push_back(rd_len);
            rd_len = 0;
        end
        if (stall_gen != stall_seen) begin
            stall_seen = stall_gen;
            stall_left = 5;
        end
        if (bus.mbus.rdn === 1'b0 && rd_len >= 2 && stall_left > 0) begin
            bus.mresp.mwait = 1'b0;
            stall_left--;
        end else begin
            bus.mresp.mwait = 1'b1;
        end
        bus.mresp.dslave = mem[bus.mbus.addr];
        if (bus.busrq_n === 1'b0 && prev_busrq) nreq++;
        if (bus.busrq_n === 1'b0) begin
            if (ack_cnt >= 3) bus.busak_n = 1'b0;
            else ack_cnt++;
        end else begin
            ack_cnt = 0;
            bus.busak_n = 1'b1;
        end
        prev_rdn   = (bus.mbus.rdn !== 1'b0);
        prev_wrn   = (bus.mbus.wrn !== 1'b0);
        prev_busrq = (bus.busrq_n !== 1'b0);
    end

    task automatic step_clk();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [7:0] v);
        bus.ibus.addr    = {12'h780, off};
        bus.ibus.dmaster = v;
        bus.ena          = 1'b1;
        bus.ibus.wrn     = 1'b0;
        step_clk();
        step_clk();
        bus.ibus.wrn = 1'b1;
        bus.ena      = 1'b0;
        step_clk();
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [7:0] v);
        bus.ibus.addr = {12'h780, off};
        bus.ena       = 1'b1;
        bus.ibus.rdn  = 1'b0;
        step_clk();
        step_clk();
        v = bus.obus.dslave;
        bus.ibus.rdn = 1'b1;
        bus.ena      = 1'b0;
        step_clk();
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] c, input logic [15:0] d);
        bus_write(4'h0, s[7:0]);
        bus_write(4'h0, s[15:8]);
        bus_write(4'h1, c[7:0]);
        bus_write(4'h1, c[15:8]);
        bus_write(4'h2, d[7:0]);
        bus_write(4'h2, d[15:8]);
        bus_write(4'h8, 8'h03);
    endtask

    task automatic pulse_drq();
        bus.drq = 1'b1;
        step_clk();
        step_clk();
        bus.drq = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (bus.busy !== 1'b1 && n < 40) begin step_clk(); n++; end
        check("busy_start", bus.busy, 1);
        n = 0;
        while (bus.busy !== 1'b0 && n < lim) begin step_clk(); n++; end
        check("busy_end", bus.busy, 0);
    endtask

    initial begin
        int rb, wb, lb, n0, bad, n;
        logic [7:0] v;

        bus.ena          = 1'b0;
        bus.drq          = 1'b0;
        bus.ibus.addr    = 16'h0000;
        bus.ibus.dmaster = 8'h00;
        bus.ibus.rdn     = 1'b1;
        bus.ibus.wrn     = 1'b1;
        bus.ibus.inta    = 1'b0;
        repeat (3) step_clk();

        check("rst_busrq_n", bus.busrq_n, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_tc", bus.tc, 0);
        check("rst_mbus", {bus.mbus.addr, bus.mbus.dmaster, bus.mbus.rdn, bus.mbus.wrn, bus.mbus.inta},
              {16'h0000, 8'h00, 1'b1, 1'b1, 1'b0});
        check("rst_obus", {bus.obus.dslave, bus.obus.mwait}, {8'h00, 1'b1});
        rst = 1'b0;
        step_clk();

        // Full sprite copy, 384 bytes.
        prog(16'h6900, 16'h017F, 16'h7000);
        rb = rd_q.size(); wb = wr_q.size(); lb = rl_q.size();
        pulse_drq();
        wait_done(6000);
        check("t1_nrd", rd_q.size() - rb, 384);
        check("t1_nwr", wr_q.size() - wb, 384);
        bad = 0;
        if (wr_q.size() >= wb + 384 && rd_q.size() >= rb + 384 && rl_q.size() >= lb + 384) begin
            check("t1_first_rd", rd_q[rb], 16'h6900);
            check("t1_last_rd", rd_q[rb+383], 16'h6A7F);
            check("t1_last_wr", wr_q[wb+383], 16'h717F);
            check("t1_pitch", rd_t[rb+1] - rd_t[rb], 10);
            for (int i = 0; i < 384; i++) begin
                if (wr_q[wb+i] !== 16'(16'h7000 + i) || wd_q[wb+i] !== pat(16'(16'h6900 + i))
                    || rl_q[lb+i] != 4) bad++;
            end
        end else begin
            bad = 999;
        end
        check("t1_copy", bad, 0);
        check("t1_tc", bus.tc, 1);
        check("t1_busrq_n", bus.busrq_n, 1);
        bus_read(4'h8, v);
        check("t1_status", v, 8'h02);
        bus_read(4'h0, v);
        check("t1_rd_other", v, 8'h00);

        // mwait stall mid-read.
        prog(16'h6A10, 16'h0000, 16'h7200);
        rb = rd_q.size(); wb = wr_q.size(); lb = rl_q.size();
        stall_gen++;
        pulse_drq();
        wait_done(200);
        check("t2_nrd", rd_q.size() - rb, 1);
        check("t2_rdlen", (rl_q.size() > lb) ? rl_q[lb] : 0, 9);
        check("t2_wr", (wr_q.size() > wb) ? {wr_q[wb], wd_q[wb]} : 24'h0, {16'h7200, pat(16'h6A10)});

        // Reset during the 10th byte's write.
        prog(16'h6900, 16'h0013, 16'h7000);
        wb = wr_q.size();
        pulse_drq();
        n = 0;
        while ((wr_q.size() - wb) < 10 && n < 400) begin step_clk(); n++; end
        check("t3_reach10", wr_q.size() - wb, 10);
        rst = 1'b1;
        step_clk();
        check("t3_busrq_n", bus.busrq_n, 1);
        check("t3_wrn", bus.mbus.wrn, 1);
        check("t3_busy", bus.busy, 0);
        rst = 1'b0;
        step_clk();
        bus_read(4'h8, v);
        check("t3_status", v, 8'h00);
        rb = rd_q.size(); wb = wr_q.size();
        bus_write(4'h8, 8'h03);
        pulse_drq();
        wait_done(200);
        check("t3_zero_regs", {rd_q.size() - rb, wr_q.size() - wb}, {32'd1, 32'd1});
        check("t3_zero_addr", (rd_q.size() > rb && wr_q.size() > wb) ? {rd_q[rb], wr_q[wb]} : 32'hDEAD,
              32'h0000_0000);

        // Register writes are ignored while busy.
        prog(16'h6900, 16'h0001, 16'h7000);
        rb = rd_q.size();
        pulse_drq();
        n = 0;
        while (bus.busy !== 1'b1 && n < 40) begin step_clk(); n++; end
        bus_write(4'h0, 8'h55);
        wait_done(200);
        check("t4_rds", (rd_q.size() == rb + 2) ? {rd_q[rb], rd_q[rb+1]} : 32'hDEAD, {16'h6900, 16'h6901});
        rb = rd_q.size();
        bus_write(4'h8, 8'h03);
        pulse_drq();
        wait_done(200);
        check("t4_src_kept", (rd_q.size() > rb) ? rd_q[rb] : 16'hDEAD, 16'h6901);

        // Only one channel enabled: no bus request.
        n0 = nreq;
        bus_write(4'h8, 8'h01);
        pulse_drq();
        repeat (30) step_clk();
        check("t5_no_req", nreq - n0, 0);
        check("t5_busrq_n", bus.busrq_n, 1);

        // drq held high triggers once; a fresh edge triggers again; mode write clears tc.
        prog(16'h6900, 16'h0000, 16'h7000);
        n0 = nreq;
        bus.drq = 1'b1;
        wait_done(200);
        repeat (200) step_clk();
        check("t6_one_xfer", nreq - n0, 1);
        bus_read(4'h8, v);
        check("t6_status", v, 8'h02);
        bus.drq = 1'b0;
        step_clk();
        step_clk();
        pulse_drq();
        wait_done(200);
        check("t6_second", nreq - n0, 2);
        bus_write(4'h8, 8'h03);
        bus_read(4'h8, v);
        check("t6_tc_clr", v, 8'h00);

        // Source address wrap.
        prog(16'hFFFF, 16'h0001, 16'h7000);
        rb = rd_q.size(); wb = wr_q.size();
        pulse_drq();
        wait_done(200);
        check("t7_rds", (rd_q.size() == rb + 2) ? {rd_q[rb], rd_q[rb+1]} : 32'hDEAD, {16'hFFFF, 16'h0000});
        check("t7_wrs", (wr_q.size() == wb + 2) ? {wd_q[wb], wd_q[wb+1]} : 16'hDEAD, {pat(16'hFFFF), pat(16'h0000)});

        check("strobe_gap", gap_err, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
